muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up applied at completion.
module muldiv_unit (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iStart,
   input  logic [2:0]  iOp,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic        oBusy,
   output logic        oDone,
   output logic [31:0] oHI,
   output logic [31:0] oLO
);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_cnt;
   logic        r_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_div0;
   logic [31:0] r_a;
   logic [31:0] r_bmag;
   logic [31:0] r_wh;
   logic [31:0] r_wl;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_start_it;
   logic        w_last;
   logic        w_sgn;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_amag;
   logic [31:0] w_bmag;
   logic [32:0] w_sum;
   logic [32:0] w_trial;
   logic        w_ok;
   logic [31:0] w_nh;
   logic [31:0] w_nl;
   logic [63:0] w_prod;
   logic [31:0] w_fin_hi;
   logic [31:0] w_fin_lo;

   function automatic logic [31:0] f_cneg32(input logic [31:0] x, input logic neg);
      logic signed [31:0] v;
      v = x;
      return neg ? 32'(-v) : x;
   endfunction

   function automatic logic [63:0] f_cneg64(input logic [63:0] x, input logic neg);
      logic signed [63:0] v;
      v = x;
      return neg ? 64'(-v) : x;
   endfunction

   assign w_accept   = iStart && (r_state != S_RUN);
   assign w_start_it = w_accept && !iOp[2];
   assign w_last     = (r_state == S_RUN) && (r_cnt == 5'd31);

   // Operand magnitudes; the unsigned ops (odd opcodes) never negate.
   assign w_sgn   = ~iOp[0];
   assign w_a_neg = w_sgn & iA[31];
   assign w_b_neg = w_sgn & iB[31];
   assign w_amag  = f_cneg32(iA, w_a_neg);
   assign w_bmag  = f_cneg32(iB, w_b_neg);

   always_comb begin
      w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_bmag} : 33'd0);
      w_trial = {r_wh, r_wl[31]} - {1'b0, r_bmag};
      w_ok    = ~w_trial[32];
      if (r_div) begin
         w_nh = w_ok ? w_trial[31:0] : {r_wh[30:0], r_wl[31]};
         w_nl = {r_wl[30:0], w_ok};
      end else begin
         w_nh = w_sum[32:1];
         w_nl = {w_sum[0], r_wl[31:1]};
      end
   end

   // Final sign fix-up; divide by zero bypasses it and returns all-ones / dividend.
   always_comb begin
      w_prod   = f_cneg64({w_nh, w_nl}, r_neg_q);
      w_fin_hi = w_prod[63:32];
      w_fin_lo = w_prod[31:0];
      if (r_div) begin
         if (r_div0) begin
            w_fin_hi = r_a;
            w_fin_lo = 32'hFFFF_FFFF;
         end else begin
            w_fin_hi = f_cneg32(w_nh, r_neg_r);
            w_fin_lo = f_cneg32(w_nl, r_neg_q);
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_start_it ? S_RUN : S_IDLE;
         S_RUN:   w_state_nxt = (r_cnt == 5'd31) ? S_DONE : S_RUN;
         S_DONE:  w_state_nxt = w_start_it ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      oBusy = (r_state == S_RUN);
      oDone = (r_state == S_DONE);
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         r_cnt   <= 5'd0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_div0  <= 1'b0;
         r_a     <= 32'd0;
         r_bmag  <= 32'd0;
         r_wh    <= 32'd0;
         r_wl    <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         if (w_start_it) begin
            r_cnt   <= 5'd0;
            r_div   <= iOp[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= (iB == 32'd0);
            r_a     <= iA;
            r_bmag  <= w_bmag;
            r_wh    <= 32'd0;
            r_wl    <= w_amag;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            r_wh  <= w_nh;
            r_wl  <= w_nl;
         end
         if (w_accept && (iOp == OP_MTHI)) begin
            r_hi <= iA;
         end
         if (w_accept && (iOp == OP_MTLO)) begin
            r_lo <= iA;
         end
         if (w_last) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
         end
      end
   end

   assign oHI = r_hi;
   assign oLO = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, signed/unsigned multiply and divide,
// divide-by-zero, overflow divide, MTHI/MTLO, ignored start, mid-run reset, back-to-back.
module tb_muldiv_unit;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iStart = 1'b0;
   logic [2:0]  iOp = 3'b000;
   logic [31:0] iA = 32'd0;
   logic [31:0] iB = 32'd0;
   logic        oBusy;
   logic        oDone;
   logic [31:0] oHI;
   logic [31:0] oLO;

   int nchk = 0;
   int nerr = 0;

   localparam logic [2:0] MULT  = 3'b000;
   localparam logic [2:0] MULTU = 3'b001;
   localparam logic [2:0] DIV   = 3'b010;
   localparam logic [2:0] DIVU  = 3'b011;
   localparam logic [2:0] MTHI  = 3'b100;
   localparam logic [2:0] MTLO  = 3'b101;

   muldiv_unit dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iStart (iStart),
      .iOp    (iOp),
      .iA     (iA),
      .iB     (iB),
      .oBusy  (oBusy),
      .oDone  (oDone),
      .oHI    (oHI),
      .oLO    (oLO)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   // Launches one op, scrambles operands during RUN, optionally pulses a second
   // start at edge t+inj, and observes 36 edges. lat is the edge count after the
   // accepting edge at which oDone is first seen (done cycle spans t+32..t+33).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output int ndone, output int nbusy,
                         output logic [63:0] mid);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      tick();
      iStart = 1'b0; iA = $urandom; iB = $urandom;
      lat = 0; ndone = 0; nbusy = 0; mid = 64'd0;
      if (oBusy) nbusy++;
      for (int k = 1; k <= 36; k++) begin
         if (k == inj) begin
            iStart = 1'b1; iOp = DIVU; iA = 32'd1; iB = 32'd1;
         end
         tick();
         iStart = 1'b0;
         if (oBusy) nbusy++;
         if (oDone) begin
            ndone++;
            if (lat == 0) lat = k;
         end
         if (k == 10) mid = {oHI, oLO};
      end
   endtask

   initial begin
      int          lat, nd, nb, e1, e2;
      logic [63:0] mid, pre;

      tick();
      tick();
      chk("rst_busy", oBusy, 1'b0);
      chk("rst_done", oDone, 1'b0);
      chk("rst_hi", oHI, 32'd0);
      chk("rst_lo", oLO, 32'd0);
      #2 iRST = 1'b1;

      pre = {oHI, oLO};
      run_op(MULT, 32'hFFFF_FFFD, 32'd7, 0, lat, nd, nb, mid);
      chk("mult_lat", lat, 32);
      chk("mult_ndone", nd, 1);
      chk("mult_busy_cycles", nb, 32);
      chk("mult_hold", mid, pre);
      chk("mult_hi", oHI, 32'hFFFF_FFFF);
      chk("mult_lo", oLO, 32'hFFFF_FFEB);
      chk("mult_idle_busy", oBusy, 1'b0);

      pre = {oHI, oLO};
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, nd, nb, mid);
      chk("multu_hold", mid, pre);
      chk("multu_hi", oHI, 32'hFFFF_FFFE);
      chk("multu_lo", oLO, 32'h0000_0001);

      run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, nd, nb, mid);
      chk("div_lo", oLO, 32'hFFFF_FFFD);
      chk("div_hi", oHI, 32'hFFFF_FFFF);

      run_op(DIVU, 32'd100, 32'd0, 0, lat, nd, nb, mid);
      chk("div0_lat", lat, 32);
      chk("div0_lo", oLO, 32'hFFFF_FFFF);
      chk("div0_hi", oHI, 32'h0000_0064);

      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, nd, nb, mid);
      chk("divovf_lo", oLO, 32'h8000_0000);
      chk("divovf_hi", oHI, 32'd0);

      iStart = 1'b1; iOp = MTLO; iA = 32'h0000_1234;
      tick();
      iStart = 1'b0;
      chk("mtlo_lo", oLO, 32'h0000_1234);
      chk("mtlo_hi", oHI, 32'd0);
      chk("mtlo_busy", oBusy, 1'b0);
      chk("mtlo_done", oDone, 1'b0);
      tick();
      chk("mtlo_busy2", oBusy, 1'b0);

      iStart = 1'b1; iOp = MTHI; iA = 32'h5A5A_0001;
      tick();
      iStart = 1'b0;
      chk("mthi_hi", oHI, 32'h5A5A_0001);
      chk("mthi_lo", oLO, 32'h0000_1234);

      iStart = 1'b1; iOp = 3'b110; iA = 32'hDEAD_BEEF;
      tick();
      iStart = 1'b0;
      tick();
      chk("rsvd_busy", oBusy, 1'b0);
      chk("rsvd_hilo", {oHI, oLO}, {32'h5A5A_0001, 32'h0000_1234});

      run_op(MULT, 32'd6, 32'd7, 5, lat, nd, nb, mid);
      chk("ign_ndone", nd, 1);
      chk("ign_lat", lat, 32);
      chk("ign_lo", oLO, 32'd42);
      chk("ign_hi", oHI, 32'd0);

      iStart = 1'b1; iOp = DIV; iA = 32'd100; iB = 32'd3;
      tick();
      iStart = 1'b0;
      repeat (9) tick();
      chk("rstrun_busy_before", oBusy, 1'b1);
      #2 iRST = 1'b0;
      #1;
      chk("rstrun_busy", oBusy, 1'b0);
      chk("rstrun_done", oDone, 1'b0);
      chk("rstrun_hilo", {oHI, oLO}, 64'd0);
      #1 iRST = 1'b1;
      run_op(DIVU, 32'd9, 32'd4, 0, lat, nd, nb, mid);
      chk("rstrun_divu_lat", lat, 32);
      chk("rstrun_divu_lo", oLO, 32'd2);
      chk("rstrun_divu_hi", oHI, 32'd1);

      iStart = 1'b1; iOp = MULTU; iA = 32'd3; iB = 32'd5;
      tick();
      iStart = 1'b0;
      e1 = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         e1 = k;
         if (oDone) break;
      end
      chk("b2b_first_done", oDone, 1'b1);
      chk("b2b_first_lat", e1, 32);
      chk("b2b_first_lo", oLO, 32'd15);
      chk("b2b_first_hi", oHI, 32'd0);
      iStart = 1'b1; iOp = DIVU; iA = 32'd9; iB = 32'd4;
      tick();
      iStart = 1'b0;
      chk("b2b_restart_busy", oBusy, 1'b1);
      e2 = 1;
      for (int k = 0; k < 40 && !oDone; k++) begin
         tick();
         e2++;
      end
      chk("b2b_second_done", oDone, 1'b1);
      chk("b2b_spacing", e2, 33);
      chk("b2b_lo", oLO, 32'd2);
      chk("b2b_hi", oHI, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
